// File: rtl/aes_mix_columns.sv
// AES MixColumns / InvMixColumns over the full 128-bit state, all four columns in parallel.
// Optional single output register stage with a valid flag; no backpressure.
module aes_mix_columns #(
    parameter int REG_OUT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic         inv,
    input  logic [127:0] state_in,
    output logic         out_valid,
    output logic [127:0] state_out
);

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // One column: a0 is the most significant byte; inverse coefficients come from
    // 2x/4x/8x chains so no multiplier tables are needed.
    function automatic logic [31:0] mix_column(input logic [31:0] col, input logic inv_mode);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] m2_0, m2_1, m2_2, m2_3;
        logic [7:0] m3_0, m3_1, m3_2, m3_3;
        logic [7:0] m4_0, m4_1, m4_2, m4_3;
        logic [7:0] m8_0, m8_1, m8_2, m8_3;
        logic [7:0] m9_0, m9_1, m9_2, m9_3;
        logic [7:0] mb_0, mb_1, mb_2, mb_3;
        logic [7:0] md_0, md_1, md_2, md_3;
        logic [7:0] me_0, me_1, me_2, me_3;
        logic [31:0] fwd_col, inv_col;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        m2_0 = xtime(a0);   m2_1 = xtime(a1);   m2_2 = xtime(a2);   m2_3 = xtime(a3);
        m3_0 = m2_0 ^ a0;   m3_1 = m2_1 ^ a1;   m3_2 = m2_2 ^ a2;   m3_3 = m2_3 ^ a3;
        m4_0 = xtime(m2_0); m4_1 = xtime(m2_1); m4_2 = xtime(m2_2); m4_3 = xtime(m2_3);
        m8_0 = xtime(m4_0); m8_1 = xtime(m4_1); m8_2 = xtime(m4_2); m8_3 = xtime(m4_3);
        m9_0 = m8_0 ^ a0;   m9_1 = m8_1 ^ a1;   m9_2 = m8_2 ^ a2;   m9_3 = m8_3 ^ a3;
        mb_0 = m9_0 ^ m2_0; mb_1 = m9_1 ^ m2_1; mb_2 = m9_2 ^ m2_2; mb_3 = m9_3 ^ m2_3;
        md_0 = m9_0 ^ m4_0; md_1 = m9_1 ^ m4_1; md_2 = m9_2 ^ m4_2; md_3 = m9_3 ^ m4_3;
        me_0 = m8_0 ^ m4_0 ^ m2_0;
        me_1 = m8_1 ^ m4_1 ^ m2_1;
        me_2 = m8_2 ^ m4_2 ^ m2_2;
        me_3 = m8_3 ^ m4_3 ^ m2_3;
        fwd_col = {m2_0 ^ m3_1 ^ a2   ^ a3,
                   a0   ^ m2_1 ^ m3_2 ^ a3,
                   a0   ^ a1   ^ m2_2 ^ m3_3,
                   m3_0 ^ a1   ^ a2   ^ m2_3};
        inv_col = {me_0 ^ mb_1 ^ md_2 ^ m9_3,
                   m9_0 ^ me_1 ^ mb_2 ^ md_3,
                   md_0 ^ m9_1 ^ me_2 ^ mb_3,
                   mb_0 ^ md_1 ^ m9_2 ^ me_3};
        return inv_mode ? inv_col : fwd_col;
    endfunction

    logic [127:0] result;

    always_comb begin
        result = '0;
        for (int c = 0; c < 4; c++) begin
            result[127 - 32*c -: 32] = mix_column(state_in[127 - 32*c -: 32], inv);
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg
            logic [127:0] state_out_d, state_out_q;
            logic         out_valid_d, out_valid_q;

            // Output holds its last value when no new state is presented.
            always_comb begin
                state_out_d = state_out_q;
                out_valid_d = in_valid;
                if (in_valid) begin
                    state_out_d = result;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_out_q <= '0;
                    out_valid_q <= 1'b0;
                end else begin
                    state_out_q <= state_out_d;
                    out_valid_q <= out_valid_d;
                end
            end

            assign state_out = state_out_q;
            assign out_valid = out_valid_q;
        end else begin : g_comb
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign state_out      = result;
            assign out_valid      = in_valid;
        end
    endgenerate

endmodule

// File: tb/tb_aes_mix_columns.sv
// Directed and random checks of aes_mix_columns (REG_OUT=1) against FIPS-197 vectors,
// a shift-and-add GF(2^8) model and the inverse round-trip identity.
module tb_aes_mix_columns;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         inv;
    logic [127:0] state_in;
    logic         out_valid;
    logic [127:0] state_out;

    int checks = 0;
    int errors = 0;

    aes_mix_columns #(.REG_OUT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .inv       (inv),
        .state_in  (state_in),
        .out_valid (out_valid),
        .state_out (state_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference multiply by the classic shift-and-add loop, independent of fixed coefficient chains.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] model_mix(input logic [127:0] s, input logic inv_mode);
        logic [7:0]   coef [4];
        logic [7:0]   a [4];
        logic [7:0]   b;
        logic [127:0] r;
        if (inv_mode) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = s[127 - 32*c - 8*j -: 8];
            for (int row = 0; row < 4; row++) begin
                b = 8'h00;
                for (int j = 0; j < 4; j++) b = b ^ gf_mul(a[j], coef[(j - row + 4) % 4]);
                r[127 - 32*c - 8*row -: 8] = b;
            end
        end
        return r;
    endfunction

    task automatic applyStimulus(input logic v, input logic i, input logic [127:0] d);
        in_valid = v;
        inv      = i;
        state_in = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    localparam logic [127:0] FIPS_COL_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] FIPS_COL_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] R1_IN        = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] R1_OUT       = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] ID_IN        = 128'hd4d4d4d5_2d26314c_f2f2f2f2_45454545;
    localparam logic [127:0] ID_OUT       = 128'hd5d5d7d6_4d7ebdf8_f2f2f2f2_45454545;

    initial begin
        logic [127:0] x, y;
        applyStimulus(1'b0, 1'b0, '0);
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_valid", {127'b0, out_valid}, 128'h0);
        checkOutput("reset_state", state_out, 128'h0);

        // Input offered while in reset must be discarded.
        applyStimulus(1'b1, 1'b0, FIPS_COL_IN);
        step();
        checkOutput("reset_discard_valid", {127'b0, out_valid}, 128'h0);
        checkOutput("reset_discard_state", state_out, 128'h0);
        applyStimulus(1'b0, 1'b0, '0);
        #3 rst_n = 1'b1;
        step();
        checkOutput("post_reset_idle", {127'b0, out_valid}, 128'h0);

        applyStimulus(1'b1, 1'b0, FIPS_COL_IN);
        step();
        checkOutput("fips_col_valid", {127'b0, out_valid}, 128'h1);
        checkOutput("fips_col", state_out, FIPS_COL_OUT);

        applyStimulus(1'b1, 1'b0, R1_IN);
        step();
        checkOutput("round1_fwd", state_out, R1_OUT);
        applyStimulus(1'b1, 1'b1, R1_OUT);
        step();
        checkOutput("round1_inv", state_out, R1_IN);

        applyStimulus(1'b1, 1'b0, '0);
        step();
        checkOutput("zero_fwd", state_out, 128'h0);
        applyStimulus(1'b1, 1'b1, '0);
        step();
        checkOutput("zero_inv", state_out, 128'h0);

        applyStimulus(1'b1, 1'b0, ID_IN);
        step();
        checkOutput("identity_cols_fwd", state_out, ID_OUT);
        applyStimulus(1'b1, 1'b1, 128'h01010101_c6c6c6c6_f2f2f2f2_45454545);
        step();
        checkOutput("equal_cols_inv", state_out, 128'h01010101_c6c6c6c6_f2f2f2f2_45454545);

        // Back-to-back stream with alternating direction, then an idle cycle.
        applyStimulus(1'b1, 1'b0, FIPS_COL_IN);
        step();
        checkOutput("stream0_valid", {127'b0, out_valid}, 128'h1);
        checkOutput("stream0", state_out, FIPS_COL_OUT);
        applyStimulus(1'b1, 1'b1, R1_OUT);
        step();
        checkOutput("stream1_valid", {127'b0, out_valid}, 128'h1);
        checkOutput("stream1", state_out, R1_IN);
        applyStimulus(1'b1, 1'b0, R1_IN);
        step();
        checkOutput("stream2_valid", {127'b0, out_valid}, 128'h1);
        checkOutput("stream2", state_out, R1_OUT);
        applyStimulus(1'b0, 1'b1, FIPS_COL_IN);
        step();
        checkOutput("idle_valid", {127'b0, out_valid}, 128'h0);
        checkOutput("idle_hold", state_out, R1_OUT);
        step();
        checkOutput("idle_hold2", state_out, R1_OUT);

        // Asynchronous reset dropped between edges.
        applyStimulus(1'b1, 1'b0, R1_IN);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", {127'b0, out_valid}, 128'h0);
        checkOutput("async_rst_state", state_out, 128'h0);
        step();
        checkOutput("rst_held_state", state_out, 128'h0);
        applyStimulus(1'b0, 1'b0, R1_IN);
        #3 rst_n = 1'b1;
        step();
        checkOutput("release_valid", {127'b0, out_valid}, 128'h0);
        checkOutput("release_state", state_out, 128'h0);
        applyStimulus(1'b1, 1'b0, R1_IN);
        step();
        checkOutput("after_release", state_out, R1_OUT);

        for (int n = 0; n < 1000; n++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(1'b1, 1'b0, x);
            step();
            checkOutput("rand_fwd", state_out, model_mix(x, 1'b0));
            y = state_out;
            applyStimulus(1'b1, 1'b1, y);
            step();
            checkOutput("rand_roundtrip", state_out, x);
            if (n % 100 == 0) begin
                applyStimulus(1'b1, 1'b1, x);
                step();
                checkOutput("rand_inv", state_out, model_mix(x, 1'b1));
            end
        end

        applyStimulus(1'b0, 1'b0, '0);
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
